// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first ripple-borrow over WIDTH cycles, result registered on DONE entry.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             bit_diff, bit_borrow;
    logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand sign bits are shifted out during SHIFT, so keep a copy for the overflow rule.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        bit_diff   = a_q[0] ^ b_q[0] ^ borrow_q;
        bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        res_shift  = {bit_diff, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StShift;
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_shift;
                borrow_d = bit_borrow;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    diff_d  = res_shift;
                    bout_d  = bit_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // bit_diff is the result MSB on the final cycle.
                    ovf_d   = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
        diff = diff_q;
        bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): latency, hold, ignore-while-busy,
// back-to-back and reset-abort behaviour.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, diff;
    logic         busy, done, bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.diff = x - y;
        e.bout = (x < y);
        e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        return e;
    endfunction

    // Every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            check("busy_with_done", {31'd0, busy}, 32'd0);
            check("sb_nonempty_on_done", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("diff", {24'd0, diff}, {24'd0, mon_e.diff});
                check("bout", {31'd0, bout}, {31'd0, mon_e.bout});
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
            end
        end
    end

    task automatic expect_latency();
        for (int i = 0; i < int'(W); i++) begin
            @(negedge clk);
            check("busy_shift", {31'd0, busy}, 32'd1);
            check("done_shift", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(x, y);
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        expect_latency();
        @(negedge clk);
        check("done_clear", {31'd0, done}, 32'd0);
        check("diff_hold", {24'd0, diff}, {24'd0, e.diff});
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'h00);
        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'h01);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'hFF);
        for (int i = 0; i < 6; i++) run_op(W'($urandom), W'($urandom));

        // start re-pulsed during SHIFT must be ignored
        n0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h10; b = 8'h01;
        sb.push_back(model(8'h10, 8'h01));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("single_done", n_done - n0, 32'd1);

        // start held high: second operands latched on the DONE cycle
        @(posedge clk); #1;
        start = 1'b1; a = 8'h20; b = 8'h10;
        sb.push_back(model(8'h20, 8'h10));
        sb.push_back(model(8'h01, 8'h02));
        @(posedge clk); #1;
        a = 8'h01; b = 8'h02;
        expect_latency();
        @(posedge clk); #1;
        start = 1'b0;
        expect_latency();
        @(negedge clk);
        check("b2b_done_clear", {31'd0, done}, 32'd0);

        // reset in the 4th SHIFT cycle aborts the operation
        @(posedge clk); #1;
        start = 1'b1; a = 8'hAA; b = 8'h55;
        sb.push_back(model(8'hAA, 8'h55));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        void'(sb.pop_back());
        n0 = n_done;
        repeat (W + 3) @(negedge clk);
        check("no_done_after_abort", n_done - n0, 32'd0);

        // start present at release must be taken on the very first edge
        rst_n = 1'b1;
        start = 1'b1; a = 8'h42; b = 8'h13;
        sb.push_back(model(8'h42, 8'h13));
        @(posedge clk); #1;
        start = 1'b0;
        expect_latency();
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
